// File: rtl/fantasma_motion_ctrl.sv
// Bouncing-sprite motion controller: advances the sprite once per frame (on the vsync falling edge)
// through a short X/Y/commit sequence, and reports where the beam sits relative to the sprite box.
module fantasma_motion_ctrl #(
    parameter int HACTIVE = 640,
    parameter int VACTIVE = 480,
    parameter int SPR_W   = 16,
    parameter int SPR_H   = 16,
    parameter int X0      = 100,
    parameter int Y0      = 50
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       vsync,
    input  logic                       pause,
    input  logic [2:0]                 speed,
    input  logic [10:0]                hc,
    input  logic [10:0]                vc,
    output logic [10:0]                spr_x,
    output logic [10:0]                spr_y,
    output logic                       dir_x,
    output logic                       dir_y,
    output logic                       frame_tick,
    output logic [7:0]                 frame_cnt,
    output logic                       in_sprite,
    output logic [$clog2(SPR_W)-1:0]   spr_px,
    output logic [$clog2(SPR_H)-1:0]   spr_py
);

    localparam int PXW = $clog2(SPR_W);
    localparam int PYW = $clog2(SPR_H);
    localparam logic [11:0] XMAX = 12'(HACTIVE - SPR_W);
    localparam logic [11:0] YMAX = 12'(VACTIVE - SPR_H);

    typedef enum logic [1:0] {IDLE, UPDX, UPDY, COMMIT} state_t;

    state_t         state_q, state_d;
    logic           vsync_q;
    logic [10:0]    spr_x_q, spr_x_d, spr_y_q, spr_y_d;
    logic           dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [10:0]    nx_q, nx_d, ny_q, ny_d;
    logic           ndx_q, ndx_d, ndy_q, ndy_d;
    logic [2:0]     spd_q, spd_d;
    logic           freeze_q, freeze_d;
    logic           tick_q, tick_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           in_q;
    logic [PXW-1:0] px_q;
    logic [PYW-1:0] py_q;

    logic           frame_evt;
    logic [10:0]    dx, dy;
    logic           hit;

    assign frame_evt = vsync_q & ~vsync;

    // Returns {new_dir, new_pos}; the sum is 12 bits wide so a near-edge position never wraps.
    function automatic logic [11:0] step_axis(input logic [10:0] pos, input logic dir,
                                              input logic [2:0] spd, input logic [11:0] lim);
        logic [11:0] sum;
        sum = {1'b0, pos} + {9'b0, spd};
        if (dir) begin
            if (sum >= lim) step_axis = {1'b0, lim[10:0]};
            else            step_axis = {1'b1, sum[10:0]};
        end else begin
            if ({1'b0, pos} <= {9'b0, spd}) step_axis = {1'b1, 11'd0};
            else                            step_axis = {1'b0, pos - {8'b0, spd}};
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        spr_x_d  = spr_x_q;
        spr_y_d  = spr_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        nx_d     = nx_q;
        ny_d     = ny_q;
        ndx_d    = ndx_q;
        ndy_d    = ndy_q;
        spd_d    = spd_q;
        freeze_d = freeze_q;
        tick_d   = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (frame_evt) state_d = UPDX;
            end
            UPDX: begin
                state_d        = UPDY;
                spd_d          = speed;
                freeze_d       = pause | (speed == 3'd0);
                {ndx_d, nx_d}  = step_axis(spr_x_q, dir_x_q, speed, XMAX);
            end
            UPDY: begin
                state_d        = COMMIT;
                {ndy_d, ny_d}  = step_axis(spr_y_q, dir_y_q, spd_q, YMAX);
            end
            COMMIT: begin
                state_d = IDLE;
                tick_d  = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                if (!freeze_q) begin
                    spr_x_d = nx_q;
                    spr_y_d = ny_q;
                    dir_x_d = ndx_q;
                    dir_y_d = ndy_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            vsync_q  <= 1'b1;
            spr_x_q  <= 11'(X0);
            spr_y_q  <= 11'(Y0);
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            nx_q     <= 11'(X0);
            ny_q     <= 11'(Y0);
            ndx_q    <= 1'b1;
            ndy_q    <= 1'b1;
            spd_q    <= 3'd0;
            freeze_q <= 1'b1;
            tick_q   <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            vsync_q  <= vsync;
            spr_x_q  <= spr_x_d;
            spr_y_q  <= spr_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            nx_q     <= nx_d;
            ny_q     <= ny_d;
            ndx_q    <= ndx_d;
            ndy_q    <= ndy_d;
            spd_q    <= spd_d;
            freeze_q <= freeze_d;
            tick_q   <= tick_d;
            cnt_q    <= cnt_d;
        end
    end

    // Unsigned subtraction: a beam left of / above the sprite wraps to a large value and misses.
    assign dx  = hc - spr_x_q;
    assign dy  = vc - spr_y_q;
    assign hit = (dx < 11'(SPR_W)) && (dy < 11'(SPR_H));

    always_ff @(posedge clk) begin
        if (reset) begin
            in_q <= 1'b0;
            px_q <= '0;
            py_q <= '0;
        end else begin
            in_q <= hit;
            px_q <= hit ? dx[PXW-1:0] : '0;
            py_q <= hit ? dy[PYW-1:0] : '0;
        end
    end

    assign spr_x      = spr_x_q;
    assign spr_y      = spr_y_q;
    assign dir_x      = dir_x_q;
    assign dir_y      = dir_y_q;
    assign frame_tick = tick_q;
    assign frame_cnt  = cnt_q;
    assign in_sprite  = in_q;
    assign spr_px     = px_q;
    assign spr_py     = py_q;

endmodule

// File: doc/fantasma_motion_ctrl.md
FANTASMA_MOTION_CTRL -- requirements
Module: fantasma_motion_ctrl

Interface
REQ-001 SHALL have parameter HACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter VACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter SPR_W, default 16, sprite width in pixels (power of two).
REQ-004 SHALL have parameter SPR_H, default 16, sprite height in lines (power of two).
REQ-005 SHALL have parameters X0 and Y0, defaults 100 and 50, the sprite reset position.
REQ-006 SHALL have port clk, input, 1 bit, the single pixel clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-008 SHALL have port vsync, input, 1 bit, active-low vertical sync from the video timing generator.
REQ-009 SHALL have port pause, input, 1 bit; 1 freezes motion.
REQ-010 SHALL have port speed, input, 3 bits, pixels moved per frame on each axis.
REQ-011 SHALL have ports hc and vc, input, 11 bits each, current beam column and line.
REQ-012 SHALL have ports spr_x and spr_y, output, 11 bits each, committed top-left sprite position.
REQ-013 SHALL have ports dir_x and dir_y, output, 1 bit each; 1 = right/down, 0 = left/up.
REQ-014 SHALL have port frame_tick, output, 1 bit, a one-cycle pulse on each position commit.
REQ-015 SHALL have port frame_cnt, output, 8 bits, count of commits, wrapping 255->0.
REQ-016 SHALL have port in_sprite, output, 1 bit; 1 = beam is inside the sprite box.
REQ-017 SHALL have ports spr_px and spr_py, output, log2(SPR_W) and log2(SPR_H) bits, beam offset inside the sprite.

Function
REQ-018 SHALL register vsync into vsync_q every cycle; a frame event is vsync_q=1 and vsync=0.
REQ-019 SHALL implement FSM states IDLE, UPDX, UPDY, COMMIT, with transitions:
- IDLE->UPDX on a frame event.
- UPDX->UPDY, UPDY->COMMIT, COMMIT->IDLE unconditionally.
REQ-020 SHALL ignore frame events arriving in UPDX, UPDY or COMMIT; they are not queued.
REQ-021 SHALL, in UPDX, compute next x into a shadow register from spr_x, dir_x and speed, using 12-bit unsigned arithmetic with no wrap:
- Right: if x+speed >= HACTIVE-SPR_W, then x = HACTIVE-SPR_W and dir_x becomes 0; otherwise x = x+speed.
- Left: if x <= speed, then x = 0 and dir_x becomes 1; otherwise x = x-speed.
REQ-022 SHALL, in UPDY, compute next y the same way using spr_y, dir_y, VACTIVE and SPR_H.
REQ-023 SHALL, in COMMIT, update spr_x, spr_y, dir_x and dir_y together, pulse frame_tick for exactly one cycle, and increment frame_cnt.
REQ-024 SHALL, while pause=1 or speed=0, leave position and direction unchanged in COMMIT while still pulsing frame_tick and incrementing frame_cnt.
REQ-025 SHALL sample pause and speed only in UPDX; a change during UPDY or COMMIT takes effect at the next frame.
REQ-026 SHALL hold spr_x, spr_y, dir_x and dir_y stable outside the COMMIT cycle.
REQ-027 SHALL assert frame_tick 3 cycles after the clock edge that first samples vsync=0.
REQ-028 SHALL register in_sprite 1 cycle after hc/vc, set to (hc-spr_x) < SPR_W and (vc-spr_y) < SPR_H using unsigned 11-bit subtraction, so hc < spr_x never matches.
REQ-029 SHALL register spr_px = (hc-spr_x) low bits and spr_py = (vc-spr_y) low bits in the same cycle as in_sprite; both are 0 when in_sprite=0.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, set:
- state = IDLE
- spr_x = X0, spr_y = Y0
- dir_x = 1, dir_y = 1
- frame_tick = 0, frame_cnt = 0
- in_sprite = 0, spr_px = 0, spr_py = 0
- vsync_q = 1, so no false frame event occurs
REQ-031 SHALL, on reset in UPDX, UPDY or COMMIT, abort the update with no commit and no frame_tick.

Verification
REQ-032 Reset, speed=2, pause=0, one vsync 1->0 -> frame_tick 3 cycles later; spr_x=102, spr_y=52, frame_cnt=1.
REQ-033 spr_x=622, dir_x=1, speed=3, frame -> spr_x=624, dir_x=0; next frame -> spr_x=621.
REQ-034 spr_y=2, dir_y=0, speed=3, frame -> spr_y=0, dir_y=1; next frame -> spr_y=3.
REQ-035 pause=1, 3 frames -> 3 frame_tick pulses, frame_cnt +3, spr_x/spr_y unchanged.
REQ-036 spr_x=100, spr_y=50, sweep hc/vc -> in_sprite=1 exactly for hc 100..115 and vc 50..65, one cycle late; spr_px=5 at hc=105.
REQ-037 reset=1 one cycle after a frame event -> no frame_tick; spr_x=X0, frame_cnt=0; a second vsync pulse in UPDY is ignored.
